ofdm_frame_mem_ctrl: RTL and testbench
======================================

OFDM_FRAME_MEM_CTRL -- requirements
Module: ofdm_frame_mem_ctrl

Interface
REQ-001 Parameter: MAX_SYMBOLS_FFT, default 64, maximum OFDM data symbols per frame.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-003 start_load  input  1  pulse: begin loading a new frame.
REQ-004 num_symbols  input  8  data symbols in the frame, sampled on start_load.
REQ-005 start_play  input  1  pulse: begin frame playout.
REQ-006 loop_en  input  1  playout repeats continuously while high.
REQ-007 abort  input  1  return to IDLE.
REQ-008 s_valid / s_ready  input / output  1 / 1  sample-in handshake.
REQ-009 mem_we  output  1  memory write enable.
REQ-010 mem_waddr / mem_raddr  output  16 / 16  memory write / read addresses.
REQ-011 m_valid / m_ready / m_last  output / input / output  1 / 1 / 1  sample-out handshake; last sample of frame.
REQ-012 frame_ready / busy / cfg_err  output  1 / 1 / 1  frame stored; load or play active; rejected num_symbols.

Function
REQ-013 Frame length L SHALL be 320 + 64*num_symbols, computed in 16 bits and latched on accepted start_load.
REQ-014 States SHALL be IDLE, LOAD, LOADED and PLAY.
REQ-015 IDLE/LOADED + start_load with 1 <= num_symbols <= MAX_SYMBOLS_FFT SHALL go to LOAD, clear wr_ptr, clear frame_ready and clear cfg_err.
REQ-016 start_load with num_symbols = 0 or > MAX_SYMBOLS_FFT SHALL set cfg_err, hold the current state, and preserve the stored frame and frame_ready.
REQ-017 In LOAD, s_ready SHALL be 1; mem_we = s_valid & s_ready (combinational); mem_waddr = wr_ptr; wr_ptr SHALL increment on each write.
REQ-018 The write at wr_ptr = L-1 SHALL move LOAD -> LOADED and set frame_ready the next cycle.
REQ-019 s_ready SHALL be 0 outside LOAD; s_valid outside LOAD SHALL be ignored with no write.
REQ-020 LOADED + start_play SHALL go to PLAY with rd_ptr = 0; start_play in IDLE, LOAD or PLAY SHALL be ignored.
REQ-021 Memory read latency is 1 cycle: data appears the cycle after mem_raddr is presented.
REQ-022 The first cycle of PLAY SHALL prime the memory, so m_valid rises 1 cycle after entry.
REQ-023 mem_raddr SHALL equal the address of the sample to be shown in the next cycle:
- advance (rd_ptr + 1, or 0 on wrap) when m_valid & m_ready;
- otherwise rd_ptr, so stalled output data is re-read unchanged.
REQ-024 m_last SHALL equal m_valid & (rd_ptr = L-1).
REQ-025 On handshake of the last sample with loop_en = 1, the block SHALL wrap to address 0 and m_valid SHALL stay 1 with no gap.
REQ-026 On handshake of the last sample with loop_en = 0, the block SHALL go to LOADED and m_valid SHALL be 0 the next cycle.
REQ-027 loop_en SHALL be sampled only at the last-sample handshake.
REQ-028 start_load during PLAY SHALL be ignored; start_load during LOAD SHALL restart the load with the newly sampled num_symbols.
REQ-029 abort in any state SHALL go to IDLE next cycle, deassert s_ready and m_valid, and clear frame_ready; abort has priority over start_load and start_play in the same cycle.
REQ-030 busy SHALL be 1 in LOAD and PLAY, 0 otherwise.
REQ-031 Pointers SHALL never exceed L-1; no write SHALL occur at an address >= L.

Reset
REQ-032 While rst_n = 0, the block SHALL be in IDLE with all outputs 0 and mem_waddr = mem_raddr = 0, wr_ptr = rd_ptr = 0, L = 0.
REQ-033 Reset mid-LOAD or mid-PLAY SHALL abandon the operation and clear frame_ready immediately (asynchronously).
REQ-034 The first start_load SHALL be accepted on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 Load: start_load with num_symbols = 1, then 384 s_valid beats -> mem_waddr 0..383; frame_ready = 1 the cycle after the beat at address 383; s_ready = 0 thereafter.
REQ-036 Play without stalls: m_ready = 1, loop_en = 0 -> m_valid for 384 consecutive cycles; m_last only on address 383; then state LOADED.
REQ-037 Stall: drop m_ready for 3 cycles at address 10 -> mem_raddr holds 10; output data unchanged; no sample skipped or duplicated.
REQ-038 Loop: loop_en = 1 with num_symbols = 2 (L = 448) -> address 447 followed by address 0 with no m_valid gap; clear loop_en -> stop after next m_last.
REQ-039 Error and abort:
- num_symbols = 0 -> cfg_err = 1, state and frame_ready unchanged;
- abort at wr_ptr = 100 -> IDLE, frame_ready = 0.
REQ-040 Reset during PLAY at address 200 -> all outputs 0 asynchronously; after release start_play is ignored until a new load completes.

Source files
------------

// File: rtl/ofdm_frame_mem_ctrl.sv
// OFDM frame memory controller.
// Loads one frame of samples into an external memory, then plays it out
// (once or looping) through a valid/ready stream with a 1-cycle read memory.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_load, num_symbols begin a load; frame length = 320 + 64*num_symbols
//   start_play, loop_en     begin playout; repeat while loop_en at frame end
//   abort                   return to idle, drop the stored frame
//   s_valid, s_ready        sample-in handshake (ready only while loading)
//   mem_we, mem_waddr       memory write port
//   mem_raddr               memory read address (data valid one cycle later)
//   m_valid, m_ready,m_last sample-out handshake, last sample of the frame
//   frame_ready, busy       frame stored; load or play in progress
//   cfg_err                 last start_load carried an unusable num_symbols
module ofdm_frame_mem_ctrl #(
    parameter int unsigned MAX_SYMBOLS_FFT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_load,
    input  logic [7:0]  num_symbols,
    input  logic        start_play,
    input  logic        loop_en,
    input  logic        abort,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        mem_we,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_raddr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        frame_ready,
    output logic        busy,
    output logic        cfg_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StLoaded, StPlay} state_e;

    state_e      state_q, state_d;
    logic [15:0] wr_ptr_q, wr_ptr_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] len_q, len_d;
    logic        frame_ready_q, frame_ready_d;
    logic        cfg_err_q, cfg_err_d;
    logic        m_valid_q, m_valid_d;

    logic        sym_ok;
    logic [15:0] len_new;
    logic        wr_last, rd_last;
    logic        handshake;
    logic        load_go, load_bad;
    logic [15:0] rd_next;

    assign sym_ok    = (num_symbols != 8'd0) && (32'(num_symbols) <= MAX_SYMBOLS_FFT);
    assign len_new   = 16'd320 + {2'b00, num_symbols, 6'b000000};
    assign wr_last   = (wr_ptr_q == len_q - 16'd1);
    assign rd_last   = (rd_ptr_q == len_q - 16'd1);
    assign handshake = m_valid_q & m_ready;
    assign rd_next   = rd_last ? 16'd0 : rd_ptr_q + 16'd1;

    // start_load is honoured everywhere except during playout.
    assign load_go  = start_load && sym_ok && (state_q != StPlay);
    assign load_bad = start_load && !sym_ok && (state_q != StPlay);

    assign s_ready     = (state_q == StLoad);
    assign mem_we      = s_valid & s_ready;
    assign mem_waddr   = wr_ptr_q;
    // Address of the sample shown next cycle: re-read the current one on stall.
    assign mem_raddr   = handshake ? rd_next : rd_ptr_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_valid_q & rd_last;
    assign frame_ready = frame_ready_q;
    assign busy        = (state_q == StLoad) || (state_q == StPlay);
    assign cfg_err     = cfg_err_q;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        len_d         = len_q;
        frame_ready_d = frame_ready_q;
        cfg_err_d     = cfg_err_q;
        m_valid_d     = m_valid_q;

        case (state_q)
            StLoaded: begin
                if (start_play && !start_load) begin
                    state_d   = StPlay;
                    rd_ptr_d  = 16'd0;
                    m_valid_d = 1'b0;
                end
            end
            StLoad: begin
                if (mem_we) begin
                    // Pointer parks on L-1 so it never exceeds the frame.
                    wr_ptr_d = wr_last ? wr_ptr_q : wr_ptr_q + 16'd1;
                    if (wr_last) begin
                        state_d       = StLoaded;
                        frame_ready_d = 1'b1;
                    end
                end
            end
            StPlay: begin
                // First cycle primes the read; data is valid from the next one.
                m_valid_d = 1'b1;
                if (handshake) begin
                    rd_ptr_d = rd_next;
                    if (rd_last && !loop_en) begin
                        state_d   = StLoaded;
                        m_valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        if (load_go) begin
            state_d       = StLoad;
            wr_ptr_d      = 16'd0;
            len_d         = len_new;
            frame_ready_d = 1'b0;
            cfg_err_d     = 1'b0;
        end else if (load_bad) begin
            cfg_err_d = 1'b1;
        end

        if (abort) begin
            state_d       = StIdle;
            wr_ptr_d      = 16'd0;
            rd_ptr_d      = 16'd0;
            frame_ready_d = 1'b0;
            m_valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= 16'd0;
            rd_ptr_q      <= 16'd0;
            len_q         <= 16'd0;
            frame_ready_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            m_valid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            len_q         <= len_d;
            frame_ready_q <= frame_ready_d;
            cfg_err_q     <= cfg_err_d;
            m_valid_q     <= m_valid_d;
        end
    end

endmodule

// File: tb/tb_ofdm_frame_mem_ctrl.sv
// Self-checking bench for ofdm_frame_mem_ctrl: a behavioural frame model plus
// a sample memory; every cycle the DUT outputs and streamed data are compared.
module tb_ofdm_frame_mem_ctrl;

    localparam int MAXS = 64;
    localparam int MI = 0, ML = 1, MLD = 2, MP = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_load = 1'b0;
    logic [7:0]  num_symbols = 8'd0;
    logic        start_play = 1'b0;
    logic        loop_en = 1'b0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        mem_we;
    logic [15:0] mem_waddr;
    logic [15:0] mem_raddr;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        frame_ready;
    logic        busy;
    logic        cfg_err;
    logic [15:0] s_data = 16'd0;

    int checks = 0;
    int failures = 0;

    ofdm_frame_mem_ctrl #(.MAX_SYMBOLS_FFT(MAXS)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .num_symbols(num_symbols),
        .start_play(start_play), .loop_en(loop_en), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .frame_ready(frame_ready),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Sample memory with 1-cycle read latency, addressed only by the DUT.
    logic [15:0] tb_mem [0:65535];
    logic [15:0] rdata = 16'd0;
    always @(posedge clk) begin
        if (mem_we) tb_mem[mem_waddr] <= s_data;
        rdata <= tb_mem[mem_raddr];
    end

    // Behavioural model: samples are indexed by arrival order, not DUT address.
    int md = MI, mlen = 0, mwcnt = 0, mrd = 0;
    bit mshown = 0, mfr = 0, merr = 0;
    logic [15:0] exp_frame [0:65535];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                md = MI; mlen = 0; mwcnt = 0; mrd = 0; mshown = 0; mfr = 0; merr = 0;
            end else if (abort) begin
                md = MI; mshown = 0; mfr = 0; mwcnt = 0; mrd = 0;
            end else begin
                if (md == MLD && start_play && !start_load) begin
                    md = MP; mrd = 0; mshown = 0;
                end else if (md == ML && s_valid) begin
                    exp_frame[mwcnt] = s_data;
                    mwcnt++;
                    if (mwcnt == mlen) begin md = MLD; mfr = 1; end
                end else if (md == MP) begin
                    if (!mshown) mshown = 1;
                    else if (m_ready) begin
                        if (mrd == mlen - 1) begin
                            mrd = 0;
                            if (!loop_en) begin md = MLD; mshown = 0; end
                        end else mrd++;
                    end
                end
                if (start_load && md != MP) begin
                    if (num_symbols >= 1 && num_symbols <= MAXS) begin
                        md = ML; mlen = 320 + 64 * int'(num_symbols); mwcnt = 0;
                        mfr = 0; merr = 0;
                    end else merr = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit ev;
        int raddr, waddr;
        ev = (md == MP) && mshown;
        raddr = (ev && m_ready) ? ((mrd == mlen - 1) ? 0 : mrd + 1) : mrd;
        waddr = (mlen != 0 && mwcnt == mlen) ? mlen - 1 : mwcnt;
        check("s_ready", 32'(s_ready), 32'(md == ML));
        check("mem_we", 32'(mem_we), 32'(md == ML && s_valid));
        check("mem_waddr", 32'(mem_waddr), 32'(waddr));
        check("mem_raddr", 32'(mem_raddr), 32'(raddr));
        check("m_valid", 32'(m_valid), 32'(ev));
        check("m_last", 32'(m_last), 32'(ev && mrd == mlen - 1));
        check("frame_ready", 32'(frame_ready), 32'(mfr));
        check("busy", 32'(busy), 32'(md == ML || md == MP));
        check("cfg_err", 32'(cfg_err), 32'(merr));
        if (ev) check("m_data", 32'(rdata), 32'(exp_frame[mrd]));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int n);
        start_load = 1'b1;
        num_symbols = 8'(n);
        tick;
        start_load = 1'b0;
    endtask

    task automatic load_frame(input int n, input int vprob, output int beats);
        beats = 0;
        pulse_load(n);
        for (int i = 0; i < 20000 && !frame_ready; i++) begin
            s_valid = ($urandom_range(99) < vprob);
            s_data = 16'($urandom);
            if (s_valid && s_ready) beats++;
            tick;
        end
        s_valid = 1'b0;
        check("load_done", 32'(frame_ready), 32'd1);
    endtask

    task automatic play_run(input int prob, input int max_cycles, output int hs, output int lasts);
        hs = 0;
        lasts = 0;
        for (int i = 0; i < max_cycles && busy; i++) begin
            m_ready = ($urandom_range(99) < prob);
            #1;
            if (m_valid && m_ready) hs++;
            if (m_last && m_ready) lasts++;
            tick;
        end
    endtask

    task automatic go_play;
        start_play = 1'b1;
        tick;
        start_play = 1'b0;
    endtask

    task automatic wait_rd(input int target);
        m_ready = 1'b1;
        for (int i = 0; i < 20000 && !(m_valid && md == MP && mrd == target); i++) tick;
        check("reach_addr", 32'(mem_raddr), 32'(target + 1));
    endtask

    initial begin
        int beats, hs, lasts;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_waddr", 32'(mem_waddr), 32'd0);
        check("rst_raddr", 32'(mem_raddr), 32'd0);
        tick; tick;
        rst_n = 1'b1;

        // Rejected symbol count in IDLE
        pulse_load(0);
        check("err_n0_cfg", 32'(cfg_err), 32'd1);
        check("err_n0_busy", 32'(busy), 32'd0);

        // Load n=1 -> 384 samples, random input gaps, stray s_valid before
        s_valid = 1'b1; tick; s_valid = 1'b0;
        load_frame(1, 70, beats);
        check("load_beats", 32'(beats), 32'd384);
        check("load_sready", 32'(s_ready), 32'd0);
        check("load_cfg_clr", 32'(cfg_err), 32'd0);

        // Play without stalls
        go_play;
        play_run(100, 2000, hs, lasts);
        check("play_hs", 32'(hs), 32'd384);
        check("play_lasts", 32'(lasts), 32'd1);
        check("play_end_ready", 32'(frame_ready), 32'd1);

        // Stall at address 10
        go_play;
        wait_rd(10);
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_raddr", 32'(mem_raddr), 32'd10);
            check("stall_valid", 32'(m_valid), 32'd1);
            tick;
        end
        play_run(60, 4000, hs, lasts);
        check("stall_hs", 32'(hs), 32'd374);
        check("stall_lasts", 32'(lasts), 32'd1);

        // Invalid counts in LOADED keep the stored frame
        pulse_load(65);
        check("err_65_cfg", 32'(cfg_err), 32'd1);
        check("err_65_ready", 32'(frame_ready), 32'd1);
        check("err_65_busy", 32'(busy), 32'd0);

        // Loop with L = 448
        load_frame(2, 90, beats);
        check("loop_beats", 32'(beats), 32'd448);
        loop_en = 1'b1;
        go_play;
        play_run(100, 1000, hs, lasts);
        check("loop_hs", 32'(hs), 32'd999);
        check("loop_lasts", 32'(lasts), 32'd2);
        loop_en = 1'b0;
        play_run(70, 4000, hs, lasts);
        check("unloop_hs", 32'(hs), 32'd345);
        check("unloop_lasts", 32'(lasts), 32'd1);

        // Abort at write pointer 100
        pulse_load(3);
        s_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin s_data = 16'($urandom); tick; end
        s_valid = 1'b0;
        check("abort_waddr", 32'(mem_waddr), 32'd100);
        abort = 1'b1; tick; abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(frame_ready), 32'd0);
        go_play;
        check("abort_noplay", 32'(busy), 32'd0);

        // Reset during PLAY at address 200
        load_frame(1, 100, beats);
        go_play;
        wait_rd(200);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(frame_ready), 32'd0);
        check("arst_raddr", 32'(mem_raddr), 32'd0);
        check("arst_last", 32'(m_last), 32'd0);
        m_ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        go_play;
        check("arst_noplay", 32'(busy), 32'd0);
        pulse_load(1);
        check("arst_reload", 32'(busy), 32'd1);

        // Random soak
        for (int c = 0; c < 25000; c++) begin
            abort = ($urandom_range(1999) == 0);
            start_load = ($urandom_range(299) == 0);
            num_symbols = 8'($urandom_range(70));
            start_play = ($urandom_range(49) == 0);
            if ($urandom_range(499) == 0) loop_en = ~loop_en;
            s_valid = ($urandom_range(99) < 80);
            m_ready = ($urandom_range(99) < 75);
            s_data = 16'($urandom);
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
